// File: rtl/wb_demux.sv
// wb_demux: routes the ALU result to the register-file write port and/or a
// valid/ready output port that has a one-entry pending buffer.
// Optional macro WB_R0_ZERO_EN: register 0 is hardwired zero, so it is never written.
module wb_demux #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              wb_valid,
  input  logic [1:0]        WB_selDEMUX,
  input  logic [ADDR_W-1:0] wbAddr,
  input  logic [DATA_W-1:0] aluResult,
  output logic              wb_stall,
  output logic              regWrEn,
  output logic [ADDR_W-1:0] regWrAddr,
  output logic [DATA_W-1:0] regWrData,
  output logic [DATA_W-1:0] outPort,
  output logic              out_valid,
  input  logic              out_ready
);
  typedef enum logic [1:0] {IDLE, SEND, SEND_PEND} state_t;
  state_t r_state, w_state_nx;
  logic [DATA_W-1:0] r_pend, w_pend_nx, w_out_nx;
  logic w_valid_nx, w_stall_nx, w_acc, w_reg, w_out;
  assign w_acc = wb_valid & ~wb_stall;
`ifdef WB_R0_ZERO_EN
  assign w_reg = w_acc & WB_selDEMUX[0] & (wbAddr != '0);
`else
  assign w_reg = w_acc & WB_selDEMUX[0];
`endif
  assign w_out = w_acc & WB_selDEMUX[1];
  // Register write port: one-cycle pulse, address/data held between writes
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      regWrEn   <= 1'b0;
      regWrAddr <= '0;
      regWrData <= '0;
    end else begin
      regWrEn <= w_reg;
      if (w_reg) begin
        regWrAddr <= wbAddr;
        regWrData <= aluResult;
      end
    end
  end
  // Output handshake next-state: a second value arriving while the port is blocked goes to pend
  always_comb begin
    w_state_nx = r_state;
    w_out_nx   = outPort;
    w_valid_nx = out_valid;
    w_stall_nx = wb_stall;
    w_pend_nx  = r_pend;
    case (r_state)
      IDLE:
        if (w_out) begin
          w_out_nx   = aluResult;
          w_valid_nx = 1'b1;
          w_state_nx = SEND;
        end
      SEND:
        if (out_ready && w_out) w_out_nx = aluResult;
        else if (out_ready) begin
          w_valid_nx = 1'b0;
          w_state_nx = IDLE;
        end else if (w_out) begin
          w_pend_nx  = aluResult;
          w_stall_nx = 1'b1;
          w_state_nx = SEND_PEND;
        end
      SEND_PEND:
        if (out_ready) begin
          w_out_nx   = r_pend;
          w_stall_nx = 1'b0;
          w_state_nx = SEND;
        end
      default: w_state_nx = IDLE;
    endcase
  end
  // Output handshake state and registered outputs
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      r_state   <= IDLE;
      r_pend    <= '0;
      outPort   <= '0;
      out_valid <= 1'b0;
      wb_stall  <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_pend    <= w_pend_nx;
      outPort   <= w_out_nx;
      out_valid <= w_valid_nx;
      wb_stall  <= w_stall_nx;
    end
  end
endmodule

// File: tb/tb_wb_demux.sv
// tb_wb_demux: directed stimulus with register-write and output-port scoreboards.
module tb_wb_demux;
  logic       clk = 1'b0, rst_n, wb_valid, out_ready;
  logic [1:0] sel, addr;
  logic [7:0] alu;
  logic       wb_stall, regWrEn, out_valid;
  logic [1:0] regWrAddr;
  logic [7:0] regWrData, outPort;
  int checks = 0, failures = 0;
  logic [7:0] oq[$];
  logic [9:0] rq[$];
  bit         prev_hold = 1'b0;
  logic [7:0] prev_out;
`ifdef WB_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  wb_demux #(.DATA_W(8), .ADDR_W(2)) dut (
    .in_clk(clk), .in_rst_n(rst_n), .wb_valid(wb_valid), .WB_selDEMUX(sel),
    .wbAddr(addr), .aluResult(alu), .wb_stall(wb_stall), .regWrEn(regWrEn),
    .regWrAddr(regWrAddr), .regWrData(regWrData), .outPort(outPort),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic req(input logic [1:0] s, input logic [1:0] a, input logic [7:0] d, input bit acc);
    wb_valid = 1'b1; sel = s; addr = a; alu = d;
    if (acc) begin
      if (s[0] && !(R0Z && a == 2'd0)) rq.push_back({a, d});
      if (s[1]) oq.push_back(d);
    end
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic chk_reset();
    chk("rst_regWrEn", regWrEn, 0);
    chk("rst_regWrAddr", regWrAddr, 0);
    chk("rst_regWrData", regWrData, 0);
    chk("rst_outPort", outPort, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_wb_stall", wb_stall, 0);
  endtask

  // Scoreboard monitor: sampled mid-cycle, when inputs and outputs are both settled
  always @(negedge clk) begin
    logic [9:0] e;
    if (rst_n === 1'b1) begin
      if (regWrEn) begin
        if (rq.size() == 0) chk("reg_unexpected", regWrEn, 0);
        else begin
          e = rq.pop_front();
          chk("reg_write", {regWrAddr, regWrData}, e);
        end
      end
      if (prev_hold) chk("out_stable", outPort, prev_out);
      if (out_valid && out_ready) begin
        if (oq.size() == 0) chk("out_unexpected", out_valid, 0);
        else chk("out_transfer", outPort, oq.pop_front());
      end
      prev_hold = out_valid && !out_ready;
      prev_out  = outPort;
    end else prev_hold = 1'b0;
  end

  initial begin
    rst_n = 1'b0; wb_valid = 1'b0; sel = 2'd0; addr = 2'd0; alu = 8'd0; out_ready = 1'b0;
    tick();
    tick();
    chk_reset();
    rst_n = 1'b1;
    // register path only
    req(2'b01, 2'd2, 8'hA5, 1);
    chk("t1_regWrEn", regWrEn, 1);
    chk("t1_regWrAddr", regWrAddr, 2);
    chk("t1_regWrData", regWrData, 8'hA5);
    tick();
    chk("t1_regWrEn_off", regWrEn, 0);
    chk("t1_out_valid", out_valid, 0);
    // output with ready held high
    out_ready = 1'b1;
    req(2'b10, 2'd0, 8'h3C, 1);
    chk("t2_valid", out_valid, 1);
    chk("t2_outPort", outPort, 8'h3C);
    tick();
    chk("t2_valid_off", out_valid, 0);
    chk("t2_outPort_hold", outPort, 8'h3C);
    // back-pressure fills pending buffer, stalls the producer
    out_ready = 1'b0;
    req(2'b10, 2'd0, 8'h11, 1);
    chk("t3_no_stall", wb_stall, 0);
    req(2'b10, 2'd0, 8'h22, 1);
    chk("t3_stall", wb_stall, 1);
    chk("t3_outPort", outPort, 8'h11);
    req(2'b11, 2'd1, 8'h33, 0);
    chk("t3_ignored_reg", regWrEn, 0);
    chk("t3_stall_hold", wb_stall, 1);
    out_ready = 1'b1;
    tick();
    chk("t3_stall_drop", wb_stall, 0);
    chk("t3_second", outPort, 8'h22);
    chk("t3_valid", out_valid, 1);
    tick();
    chk("t3_idle", out_valid, 0);
    // streaming without bubbles
    for (int i = 1; i <= 4; i++) begin
      req(2'b10, 2'd0, 8'(i), 1);
      chk("t4_valid", out_valid, 1);
      chk("t4_data", outPort, i);
      chk("t4_stall", wb_stall, 0);
    end
    tick();
    chk("t4_idle", out_valid, 0);
    // reset while a value is pending
    out_ready = 1'b0;
    req(2'b10, 2'd0, 8'hAA, 1);
    req(2'b10, 2'd0, 8'hBB, 1);
    chk("t5_stall", wb_stall, 1);
    rst_n = 1'b0;
    tick();
    oq.delete();
    rst_n = 1'b1;
    chk_reset();
    out_ready = 1'b1;
    req(2'b10, 2'd0, 8'h55, 1);
    chk("t5_new", outPort, 8'h55);
    chk("t5_valid", out_valid, 1);
    tick();
    chk("t5_idle", out_valid, 0);
    chk("t5_hold", outPort, 8'h55);
    // select 00 has no effect
    req(2'b00, 2'd3, 8'hEE, 1);
    chk("t6_none_reg", regWrEn, 0);
    chk("t6_none_out", out_valid, 0);
    // select 11 to register 0
    req(2'b11, 2'd0, 8'h7F, 1);
    chk("t7_regWrEn", regWrEn, R0Z ? 0 : 1);
    if (!R0Z) chk("t7_regWrAddr", regWrAddr, 0);
    chk("t7_outPort", outPort, 8'h7F);
    chk("t7_valid", out_valid, 1);
    tick();
    tick();
    chk("oq_empty", oq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
